seq_detector_param: RTL and testbench
=====================================

# seq_detector_param

Parametrised Moore serial-pattern detector. It samples one bit per enabled clock on `X` and compares the most recent `N` bits against a pattern register that can be reloaded at runtime. It asserts a registered match flag and keeps a saturating match count. The block sits next to the fixed-pattern detectors in the lab datapath and replaces hand-coded state encodings for any pattern up to `N` bits, with selectable overlap behaviour.

## Interface

- `N`, 4, pattern length in bits (N ≥ 2)
- `PATTERN`, 4'b1011, reset value of the pattern register; the MSB is the first bit received
- `CW`, 8, match-counter width
- `CLK` input 1 rising-edge clock
- `RST` input 1 asynchronous active-high reset
- `X` input 1 serial data bit, sampled when `EN`=1
- `EN` input 1 sample enable
- `OVERLAP` input 1 1 = overlapping matches allowed; 0 = history restarts after each match
- `LOAD` input 1 synchronous pattern load strobe
- `PAT_IN` input N new pattern, captured when `LOAD`=1
- `CLR` input 1 synchronous clear of the match counter
- `Z` output 1 registered match flag (Moore)
- `CNT` output CW saturating count of matches
- `FILL` output $clog2(N+1) number of valid history bits, 0..N

## Operation

- Internal registers:
  - `pat[N-1:0]`: the pattern.
  - `hist[N-1:0]`: history; newest bit in the LSB, shifted left on each sample.
  - `FILL`: occupancy counter.
  - `Z`.
  - `CNT`.
- Reset (asynchronous, immediate): `pat`=`PATTERN`, `hist`=0, `FILL`=0, `Z`=0, `CNT`=0.
- Per-edge priority is `LOAD`, then `EN`.
- **`LOAD`=1:**
  - `pat`←`PAT_IN`, `hist`←0, `FILL`←0, `Z`←0.
  - `X` is ignored that cycle.
  - `CNT` is unaffected unless `CLR` is also asserted.
- **`LOAD`=0, `EN`=1:**
  - Candidate history is `h'={hist[N-2:0],X}` and candidate fill is `f'=min(FILL+1,N)`.
  - Match = (`f'`==N) and (`h'`==`pat`).
  - On match:
    - `Z`←1.
    - `CNT`←`CNT`+1, saturating at 2^CW−1.
    - If `OVERLAP`=1: `hist`←`h'`, `FILL`←N.
    - If `OVERLAP`=0: `hist`←0, `FILL`←0.
  - On no match: `Z`←0, `hist`←`h'`, `FILL`←`f'`.
- **`LOAD`=0, `EN`=0:** `hist` and `FILL` hold, `Z`←0. A match is never reported twice.
- **`CLR`=1:** `CNT`←0, independent of `LOAD` and `EN`.
  - If a match occurs in the same cycle, the clear wins and `CNT`=0.
- Lifecycle states: EMPTY (`FILL`=0) → FILLING (0<`FILL`<N) → FULL (`FILL`=N).
  - FULL is left only via `LOAD`, `RST`, or a non-overlap match.
- `OVERLAP` is sampled every cycle. Changing it mid-stream takes effect at the next match.

## Timing

- Detection latency is one cycle: `Z` is high for exactly the cycle after the edge that samples the final pattern bit.
- `Z` and `CNT` are register outputs with no combinational path from `X`.
- Back-to-back matches are possible with `OVERLAP`=1, e.g. an all-ones pattern on an all-ones stream.
  - In that case `Z` stays high on consecutive cycles and `CNT` increments every cycle.
- The first possible `Z` comes N edges after reset or `LOAD`, counting enabled edges only.
- Reset asserted mid-stream clears everything at once, with no wait for `CLK`.
  - Detection restarts from EMPTY on the first enabled edge after `RST` falls.
- `CNT` saturation: at 2^CW−1 a further match leaves `CNT` unchanged while `Z` still pulses.

## Test plan

- **Overlap:** defaults, `OVERLAP`=1, `EN`=1, stream 1,0,1,1,0,1,1 → `Z`=1 in the cycles after bits 4 and 7 only; `CNT`=2.
- **Non-overlap:** same stream with `OVERLAP`=0 → `Z` only after bit 4; `FILL`=3 at the end; `CNT`=1.
- **Enable gaps:** drive 1,0 with `EN`=1, then 3 cycles with `EN`=0 and `X` toggling, then 1,1 with `EN`=1 → `Z` pulses once after the last 1; `FILL` holds at 2 during the gap.
- **Runtime load:** `LOAD` with `PAT_IN`=4'b0000 after 2 bits → `FILL`=0, `Z`=0. Then six 0s → `Z` high for 3 consecutive cycles; `CNT`=3.
- **Saturation / CLR:** `CW`=2, all-ones pattern and stream, `OVERLAP`=1 → `CNT` reaches 3 and holds while `Z` stays 1. `CLR` pulsed together with a match → `CNT`=0 next cycle.
- **Asynchronous reset:** assert `RST` between clock edges mid-pattern → `Z`, `CNT`, `FILL` go to 0 immediately and `pat` returns to 4'b1011. The stream 1,0,1,1 after release → one `Z` pulse.

Source files
------------

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parametrised Moore serial-pattern detector with runtime pattern load
//
// Purpose:
//   Shifts one bit per enabled clock from X into an N-bit history and
//   raises a registered match flag the cycle after the history equals the
//   pattern register. Matches are counted in a saturating counter. The
//   pattern can be reloaded at runtime, and OVERLAP selects whether the
//   history is kept (overlapping matches) or restarted after each match.
//
// Parameters:
//   N        pattern length in bits (N >= 2)
//   PATTERN  reset value of the pattern register, MSB is the first bit received
//   CW       match-counter width
//
// Ports:
//   CLK      rising-edge clock
//   RST      asynchronous active-high reset
//   X        serial data bit, sampled when EN=1
//   EN       sample enable
//   OVERLAP  1 = overlapping matches allowed, 0 = history restarts after a match
//   LOAD     synchronous pattern load strobe (has priority over EN)
//   PAT_IN   new pattern, captured when LOAD=1
//   CLR      synchronous clear of the match counter (wins over an increment)
//   Z        registered match flag
//   CNT      saturating match count
//   FILL     number of valid history bits, 0..N

module seq_detector_param #(
   parameter int             N       = 4,
   parameter logic [N-1:0]   PATTERN = 4'b1011,
   parameter int             CW      = 8
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       X,
   input  logic                       EN,
   input  logic                       OVERLAP,
   input  logic                       LOAD,
   input  logic [N-1:0]               PAT_IN,
   input  logic                       CLR,
   output logic                       Z,
   output logic [CW-1:0]              CNT,
   output logic [$clog2(N+1)-1:0]     FILL
);

   localparam int             FW       = $clog2(N + 1);
   localparam logic [FW-1:0]  FILL_MAX = FW'(N);
   localparam logic [CW-1:0]  CNT_MAX  = {CW{1'b1}};

   // Occupancy lifecycle; kept alongside FILL so the "history full" test
   // does not need a magnitude compare on the counter.
   typedef enum logic [1:0] {
      S_EMPTY   = 2'd0,
      S_FILLING = 2'd1,
      S_FULL    = 2'd2
   } fill_state_t;

   fill_state_t      state;
   logic [N-1:0]     pat;
   logic [N-1:0]     hist;

   logic [N-1:0]     hist_next;
   logic [FW-1:0]    fill_next;
   logic             hit;
   logic [CW-1:0]    cnt_inc;

   // Candidate history/fill as if the current X were accepted. Once FULL the
   // fill saturates at N, so only the state is needed to pick the value.
   always_comb begin
      hist_next = {hist[N-2:0], X};
      fill_next = (state == S_FULL) ? FILL_MAX : (FILL + FW'(1));
      hit       = (fill_next == FILL_MAX) && (hist_next == pat);
      cnt_inc   = (CNT == CNT_MAX) ? CNT : (CNT + CW'(1));
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pat   <= PATTERN;
         hist  <= '0;
         FILL  <= '0;
         state <= S_EMPTY;
         Z     <= 1'b0;
         CNT   <= '0;
      end else begin
         // Counter clear is independent of LOAD/EN; the match branch below
         // only increments when CLR is low, so clear wins on a collision.
         if (CLR) begin
            CNT <= '0;
         end

         if (LOAD) begin
            pat   <= PAT_IN;
            hist  <= '0;
            FILL  <= '0;
            state <= S_EMPTY;
            Z     <= 1'b0;
         end else if (EN) begin
            if (hit) begin
               Z <= 1'b1;
               if (!CLR) begin
                  CNT <= cnt_inc;
               end
               if (OVERLAP) begin
                  hist  <= hist_next;
                  FILL  <= FILL_MAX;
                  state <= S_FULL;
               end else begin
                  hist  <= '0;
                  FILL  <= '0;
                  state <= S_EMPTY;
               end
            end else begin
               Z     <= 1'b0;
               hist  <= hist_next;
               FILL  <= fill_next;
               state <= (fill_next == FILL_MAX) ? S_FULL : S_FILLING;
            end
         end else begin
            // Holding: a match already reported must not pulse again.
            Z <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - scoreboard bench for seq_detector_param

module tb_seq_detector_param;

   localparam int N  = 4;
   localparam int CW = 2;
   localparam int FW = $clog2(N + 1);

   logic           CLK = 1'b0;
   logic           RST;
   logic           X;
   logic           EN;
   logic           OVERLAP;
   logic           LOAD;
   logic [N-1:0]   PAT_IN;
   logic           CLR;
   logic           Z;
   logic [CW-1:0]  CNT;
   logic [FW-1:0]  FILL;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic           z;
      logic [CW-1:0]  cnt;
      logic [FW-1:0]  fill;
      string          tag;
   } exp_t;

   exp_t sb[$];

   seq_detector_param #(
      .N       (N),
      .PATTERN (4'b1011),
      .CW      (CW)
   ) dut (
      .CLK     (CLK),
      .RST     (RST),
      .X       (X),
      .EN      (EN),
      .OVERLAP (OVERLAP),
      .LOAD    (LOAD),
      .PAT_IN  (PAT_IN),
      .CLR     (CLR),
      .Z       (Z),
      .CNT     (CNT),
      .FILL    (FILL)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: the DUT presents a Moore output every cycle; compare it away
   // from the active edge against whatever the driver queued.
   always @(negedge CLK) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         check({e.tag, ".Z"},    int'(Z),    int'(e.z));
         check({e.tag, ".CNT"},  int'(CNT),  int'(e.cnt));
         check({e.tag, ".FILL"}, int'(FILL), int'(e.fill));
      end
   end

   // One clock: drive inputs, let the edge happen, queue the expected result.
   task automatic step(input logic x, input logic en, input logic ov,
                       input logic ld, input logic [N-1:0] pin, input logic clr,
                       input logic ez, input int ecnt, input int efill,
                       input string tag);
      exp_t e;
      X = x; EN = en; OVERLAP = ov; LOAD = ld; PAT_IN = pin; CLR = clr;
      @(posedge CLK);
      e.z = ez; e.cnt = CW'(ecnt); e.fill = FW'(efill); e.tag = tag;
      sb.push_back(e);
      @(negedge CLK);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      RST = 1'b1; X = 1'b0; EN = 1'b0; OVERLAP = 1'b1;
      LOAD = 1'b0; PAT_IN = '0; CLR = 1'b0;
      #12;
      check("reset.Z",    int'(Z),    0);
      check("reset.CNT",  int'(CNT),  0);
      check("reset.FILL", int'(FILL), 0);
      @(negedge CLK);
      RST = 1'b0;

      // Overlap: 1,0,1,1,0,1,1 -> Z after bits 4 and 7
      step(1, 1, 1, 0, 4'h0, 0, 0, 0, 1, "ov1");
      step(0, 1, 1, 0, 4'h0, 0, 0, 0, 2, "ov2");
      step(1, 1, 1, 0, 4'h0, 0, 0, 0, 3, "ov3");
      step(1, 1, 1, 0, 4'h0, 0, 1, 1, 4, "ov4");
      step(0, 1, 1, 0, 4'h0, 0, 0, 1, 4, "ov5");
      step(1, 1, 1, 0, 4'h0, 0, 0, 1, 4, "ov6");
      step(1, 1, 1, 0, 4'h0, 0, 1, 2, 4, "ov7");
      step(0, 0, 1, 0, 4'h0, 0, 0, 2, 4, "ov_hold");
      step(1, 1, 1, 1, 4'b1011, 1, 0, 0, 0, "ov_ldclr");

      // Non-overlap: same stream -> Z after bit 4 only, FILL ends at 3
      step(1, 1, 0, 0, 4'h0, 0, 0, 0, 1, "no1");
      step(0, 1, 0, 0, 4'h0, 0, 0, 0, 2, "no2");
      step(1, 1, 0, 0, 4'h0, 0, 0, 0, 3, "no3");
      step(1, 1, 0, 0, 4'h0, 0, 1, 1, 0, "no4");
      step(0, 1, 0, 0, 4'h0, 0, 0, 1, 1, "no5");
      step(1, 1, 0, 0, 4'h0, 0, 0, 1, 2, "no6");
      step(1, 1, 0, 0, 4'h0, 0, 0, 1, 3, "no7");
      step(0, 0, 1, 1, 4'b1011, 1, 0, 0, 0, "no_ldclr");

      // Enable gaps: FILL holds at 2 while X toggles with EN=0
      step(1, 1, 1, 0, 4'h0, 0, 0, 0, 1, "gap1");
      step(0, 1, 1, 0, 4'h0, 0, 0, 0, 2, "gap2");
      step(1, 0, 1, 0, 4'h0, 0, 0, 0, 2, "gap_off1");
      step(0, 0, 1, 0, 4'h0, 0, 0, 0, 2, "gap_off2");
      step(1, 0, 1, 0, 4'h0, 0, 0, 0, 2, "gap_off3");
      step(1, 1, 1, 0, 4'h0, 0, 0, 0, 3, "gap3");
      step(1, 1, 1, 0, 4'h0, 0, 1, 1, 4, "gap4");
      step(1, 0, 1, 0, 4'h0, 0, 0, 1, 4, "gap_noretrig");

      // Runtime load of 0000 after 2 bits, then six zeros
      step(0, 0, 1, 1, 4'b1011, 1, 0, 0, 0, "rl_ldclr");
      step(1, 1, 1, 0, 4'h0, 0, 0, 0, 1, "rl1");
      step(0, 1, 1, 0, 4'h0, 0, 0, 0, 2, "rl2");
      step(1, 1, 1, 1, 4'b0000, 0, 0, 0, 0, "rl_load");
      step(0, 1, 1, 0, 4'h0, 0, 0, 0, 1, "rl_z1");
      step(0, 1, 1, 0, 4'h0, 0, 0, 0, 2, "rl_z2");
      step(0, 1, 1, 0, 4'h0, 0, 0, 0, 3, "rl_z3");
      step(0, 1, 1, 0, 4'h0, 0, 1, 1, 4, "rl_z4");
      step(0, 1, 1, 0, 4'h0, 0, 1, 2, 4, "rl_z5");
      step(0, 1, 1, 0, 4'h0, 0, 1, 3, 4, "rl_z6");
      step(0, 0, 1, 0, 4'h0, 0, 0, 3, 4, "rl_idle");

      // Saturation at 3 with all-ones, then CLR colliding with a match
      step(1, 1, 1, 1, 4'b1111, 1, 0, 0, 0, "sat_ldclr");
      step(1, 1, 1, 0, 4'h0, 0, 0, 0, 1, "sat1");
      step(1, 1, 1, 0, 4'h0, 0, 0, 0, 2, "sat2");
      step(1, 1, 1, 0, 4'h0, 0, 0, 0, 3, "sat3");
      step(1, 1, 1, 0, 4'h0, 0, 1, 1, 4, "sat4");
      step(1, 1, 1, 0, 4'h0, 0, 1, 2, 4, "sat5");
      step(1, 1, 1, 0, 4'h0, 0, 1, 3, 4, "sat6");
      step(1, 1, 1, 0, 4'h0, 0, 1, 3, 4, "sat7_hold");
      step(1, 1, 1, 0, 4'h0, 0, 1, 3, 4, "sat8_hold");
      step(1, 1, 1, 0, 4'h0, 1, 1, 0, 4, "sat_clr_wins");
      step(1, 1, 1, 0, 4'h0, 0, 1, 1, 4, "sat_after_clr");
      step(1, 1, 1, 1, 4'b0110, 0, 0, 1, 0, "load_keeps_cnt");

      // Asynchronous reset mid-pattern restores the 1011 pattern
      step(1, 1, 1, 0, 4'h0, 0, 0, 1, 1, "ar1");
      step(0, 1, 1, 0, 4'h0, 0, 0, 1, 2, "ar2");
      #2;
      RST = 1'b1;
      #1;
      check("async_rst.Z",    int'(Z),    0);
      check("async_rst.CNT",  int'(CNT),  0);
      check("async_rst.FILL", int'(FILL), 0);
      @(negedge CLK);
      RST = 1'b0;
      step(1, 1, 1, 0, 4'h0, 0, 0, 0, 1, "pr1");
      step(0, 1, 1, 0, 4'h0, 0, 0, 0, 2, "pr2");
      step(1, 1, 1, 0, 4'h0, 0, 0, 0, 3, "pr3");
      step(1, 1, 1, 0, 4'h0, 0, 1, 1, 4, "pr4");
      step(0, 1, 1, 0, 4'h0, 0, 0, 1, 4, "pr5");

      #1;
      check("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
